// File: rtl/alu_sched_pkg.sv
// Shared constants for the ALU operation scheduler: opcode values,
// FSM state encoding and the default data width.
package alu_sched_pkg;

  localparam int DW_DEF = 32;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_THR  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_AND  = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_HOLD = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/alu_op_scheduler_rr_arb2.sv
// Two-way round-robin arbiter. When both requesters are valid the one that
// did not win last time is granted; a lone valid requester always wins.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  // Pick the winner from the current valids and the previous grant.
  always_comb begin
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) grant_id = ~last_grant;
    else                  grant_id = valid1;
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: round-robin arbitration, operand
// registration, a wait of ALU_LAT edges and a tagged valid/ready response.
// Optional macro ALU_SCHED_PERF_EN adds per-requester completion counters and
// a response back-pressure cycle counter.
//
// state    | meaning
// ST_IDLE  | arbitrating, ready offered to the granted requester
// ST_ISSUE | alu_start high, latched op/operands presented to the ALU
// ST_WAIT  | ALU told to hold, counting down its latency
// ST_RESP  | result held on the response channel until accepted
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [2:0]    req0_op,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [2:0]    req1_op,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic          alu_start,
  output logic [2:0]    alu_opcode,
  output logic [DW-1:0] alu_acout,
  output logic [DW-1:0] alu_b_in,
  input  logic [DW-1:0] alu_result,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          busy
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_ops0,
  output logic [31:0]   perf_ops1,
  output logic [31:0]   perf_stall
`endif
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  sched_state_t state;
  logic         last_grant;
  logic [3:0]   cnt;
  logic         grant_valid;
  logic         grant_id;

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  assign req0_ready = (state == ST_IDLE) & grant_valid & ~grant_id;
  assign req1_ready = (state == ST_IDLE) & grant_valid &  grant_id;
  assign busy       = (state != ST_IDLE);

  // Sequencer: accept, issue for one cycle, wait out the ALU latency, respond.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      alu_start  <= 1'b0;
      alu_opcode <= OP_HOLD;
      alu_acout  <= '0;
      alu_b_in   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            state      <= ST_ISSUE;
            alu_start  <= 1'b1;
            alu_opcode <= grant_id ? req1_op : req0_op;
            alu_acout  <= grant_id ? req1_a  : req0_a;
            alu_b_in   <= grant_id ? req1_b  : req0_b;
            rsp_id     <= grant_id;
            last_grant <= grant_id;
          end
        end
        ST_ISSUE: begin
          state      <= ST_WAIT;
          alu_start  <= 1'b0;
          alu_opcode <= OP_HOLD;
          cnt        <= LAT_M1;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data  <= alu_result;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SCHED_PERF_EN
  // Count completed responses per requester and back-pressured response cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops0  <= '0;
      perf_ops1  <= '0;
      perf_stall <= '0;
    end else begin
      if (rsp_valid && rsp_ready && !rsp_id) perf_ops0 <= perf_ops0 + 32'd1;
      if (rsp_valid && rsp_ready &&  rsp_id) perf_ops1 <= perf_ops1 + 32'd1;
      if (rsp_valid && !rsp_ready)           perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed scenarios plus a
// randomized run, with ALU models of latency 1 and 3 and a reference model
// of arbitration order, response latency and result values.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
  logic [2:0]  req0_op = 0, req1_op = 0;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, alu_start, rsp_valid, rsp_id, busy;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_acout, alu_b_in, alu_result, rsp_data;

  logic        x_v0 = 0;
  logic [31:0] x_a = 0, x_b = 0;
  logic [2:0]  x_op = 0;
  logic        x_ready0, x_ready1, x_start, x_rsp_valid, x_rsp_id, x_busy;
  logic [2:0]  x_opcode;
  logic [31:0] x_acout, x_b_in, x_result, x_rsp_data;

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_ops0, perf_ops1, perf_stall;
  logic [31:0] x_perf_ops0, x_perf_ops1, x_perf_stall;
`endif

  alu_op_scheduler #(.DW(32), .ALU_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_acout(alu_acout), .alu_b_in(alu_b_in),
    .alu_result(alu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_ops0(perf_ops0), .perf_ops1(perf_ops1), .perf_stall(perf_stall)
`endif
  );

  alu_op_scheduler #(.DW(32), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(x_v0), .req0_ready(x_ready0), .req0_op(x_op), .req0_a(x_a), .req0_b(x_b),
    .req1_valid(1'b0), .req1_ready(x_ready1), .req1_op(3'b000), .req1_a(32'd0), .req1_b(32'd0),
    .alu_start(x_start), .alu_opcode(x_opcode), .alu_acout(x_acout), .alu_b_in(x_b_in),
    .alu_result(x_result), .rsp_valid(x_rsp_valid), .rsp_ready(1'b1), .rsp_id(x_rsp_id),
    .rsp_data(x_rsp_data), .busy(x_busy)
`ifdef ALU_SCHED_PERF_EN
    , .perf_ops0(x_perf_ops0), .perf_ops1(x_perf_ops1), .perf_stall(x_perf_stall)
`endif
  );

  function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return 32'd0;
      3'b001:  return a;
      3'b010:  return a + b;
      3'b011:  return a - b;
      3'b100:  return a | b;
      3'b101:  return a & b;
      3'b110:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // ALU models: result computed when started, then held and delayed by the latency.
  logic [31:0] p1;
  logic [31:0] p3 [3];
  always_ff @(posedge clk) begin
    if (alu_start && alu_opcode != 3'b111) p1 <= alu_f(alu_opcode, alu_acout, alu_b_in);
    if (x_start && x_opcode != 3'b111) p3[0] <= alu_f(x_opcode, x_acout, x_b_in);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign alu_result = p1;
  assign x_result   = p3[2];

  int checks = 0;
  int failures = 0;
  logic m_last = 1'b1;
  int m_ops0 = 0, m_ops1 = 0, m_stall = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one transaction starting at a negedge with the DUT idle; ends at the
  // negedge after the response handshake.
  task automatic do_op(input logic v0, input logic v1,
                       input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int stall);
    logic w;
    logic [2:0] eop;
    logic [31:0] ea, eb, ed;
    int n;
    w   = (v0 && v1) ? ~m_last : v1;
    eop = w ? op1 : op0;
    ea  = w ? a1 : a0;
    eb  = w ? b1 : b0;
    ed  = alu_f(eop, ea, eb);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    rsp_ready  = (stall == 0);
    #1;
    check("grant_ready0", req0_ready, !w);
    check("grant_ready1", req1_ready, w);
    m_last = w;
    @(posedge clk);
    @(negedge clk);
    check("issue_start", alu_start, 1'b1);
    check("issue_opcode", alu_opcode, eop);
    check("issue_a", alu_acout, ea);
    check("issue_b", alu_b_in, eb);
    check("issue_busy", busy, 1'b1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("wait_start", alu_start, 1'b0);
        check("wait_opcode", alu_opcode, 3'b111);
        check("wait_a_held", alu_acout, ea);
      end
    end
    check("rsp_latency", n, LAT + 1);
    check("rsp_data", rsp_data, ed);
    check("rsp_id", rsp_id, w);
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", rsp_data, ed);
      check("stall_id", rsp_id, w);
      check("stall_ready", {req1_ready, req0_ready}, 2'b00);
      m_stall++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("rsp_done", rsp_valid, 1'b0);
    check("idle_busy", busy, 1'b0);
    if (w) m_ops1++; else m_ops0++;
  endtask

  initial begin
    int n;
    // Reset check
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_start", alu_start, 1'b0);
    check("rst_opcode", alu_opcode, 3'b111);
    check("rst_a", alu_acout, 32'd0);
    check("rst_b", alu_b_in, 32'd0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", {req1_ready, req0_ready}, 2'b00);

    // Single op, then contention (alternating ids), then back-pressure
    do_op(1, 0, OP_ADD, 5, 3, OP_CLR, 0, 0, 0);
    req0_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      do_op(1, 1, OP_ADD, 1, 1, OP_SUB, 0, 1, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    do_op(1, 0, OP_XOR, 32'hFFFF0000, 32'h00FFFF00, OP_CLR, 0, 0, 5);
    req0_valid = 0;

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      if (!v0 && !v1) v0 = 1'b1;
      do_op(v0, v1, 3'($urandom_range(0, 6)), $urandom, $urandom,
            3'($urandom_range(0, 6)), $urandom, $urandom, $urandom_range(0, 3));
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);

`ifdef ALU_SCHED_PERF_EN
    check("perf_ops0", perf_ops0, m_ops0);
    check("perf_ops1", perf_ops1, m_ops1);
    check("perf_stall", perf_stall, m_stall);
`endif

    // Reset in WAIT after an AND request
    req0_valid = 1; req0_op = OP_AND; req0_a = 32'hF0; req0_b = 32'h3C;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 0;
    @(negedge clk);
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_rsp_valid", rsp_valid, 1'b0);
    check("midrst_opcode", alu_opcode, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    m_last = 1'b1; m_ops0 = 0; m_ops1 = 0; m_stall = 0;
    repeat (3) @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 1'b0);
    do_op(1, 0, OP_OR, 4, 1, OP_CLR, 0, 0, 0);
    req0_valid = 0;
    @(negedge clk);

    // Latency-3 instance: ADD 10+20
`ifdef ALU_SCHED_PERF_EN
    check("lat3_perf_before", x_perf_ops0, 32'd0);
`endif
    x_v0 = 1; x_op = OP_ADD; x_a = 10; x_b = 20;
    #1;
    check("lat3_ready", x_ready0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    x_v0 = 0;
    check("lat3_start", x_start, 1'b1);
    n = 0;
    while (!x_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("lat3_latency", n, 4);
    check("lat3_data", x_rsp_data, 32'd30);
    check("lat3_id", x_rsp_id, 1'b0);
    @(negedge clk);
    check("lat3_done", x_rsp_valid, 1'b0);
    check("lat3_ready1", x_ready1, 1'b0);
`ifdef ALU_SCHED_PERF_EN
    check("lat3_perf_after", x_perf_ops0, 32'd1);
    check("perf_ops0_after_rst", perf_ops0, m_ops0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares the single 32-bit ALU between two requesters (e.g. the fetch/execute path and a DMA/test port).
- Arbitrates round-robin, registers the operands and issues one operation at a time.
- Waits the ALU's registered latency, then returns the result tagged with the requester id over a valid/ready response channel.
- Sits between the control unit and the ALU; the ALU's ports connect straight to the alu_* ports below.

Parameters:
- DW, 32, operand/result width.
- ALU_LAT, 1, ALU result latency in clock edges after the issue edge; legal range 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: one clock; reset is asynchronous and active-low (rst=0 resets).
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this edge.
- req0_op  input  3  ALU opcode.
- req0_a  input  DW  operand A (acout).
- req0_b  input  DW  operand B (B_in).
- req1_valid / req1_ready / req1_op / req1_a / req1_b  as requester 0.
- alu_start  output  1  high only in ISSUE.
- alu_opcode  output  3  opcode to ALU.
- alu_acout  output  DW  operand A to ALU.
- alu_b_in  output  DW  operand B to ALU.
- alu_result  input  DW  ALU output (alout).
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  1  requester that issued the op.
- rsp_data  output  DW  result.
- busy  output  1  state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, all *_ready=0, alu_start=0, alu_opcode=3'b111 (ALU hold), alu_acout=0, alu_b_in=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, last_grant=1 (so requester 0 wins first).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - grant = the sole valid requester; if both are valid, the one != last_grant.
  - reqN_ready = (state==IDLE) & grant==N (combinational from valid and last_grant).
  - On the handshake edge: latch op/a/b/id, set last_grant=id, go to ISSUE.
- ISSUE (one cycle):
  - alu_start=1; alu_opcode/acout/b_in = the latched values.
  - Next edge: go to WAIT and load a 4-bit counter with ALU_LAT-1.
- WAIT:
  - alu_start=0; alu_opcode=3'b111 so the ALU holds its output; operands are held.
  - Counter decrements each edge.
  - When it reaches 0: capture alu_result into rsp_data, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid & rsp_ready.
  - On that edge: rsp_valid=0, go to IDLE.
  - No new request is accepted in the RESP cycle.
- Latency with ALU_LAT=1: accept at edge E0, ALU samples at E1, rsp_valid rises after E2. In general ALU_LAT+1 edges after acceptance.
- Throughput: at most one op per ALU_LAT+3 cycles with rsp_ready tied high.
- Opcodes are forwarded unmodified, including 000 (clear) and 111 (hold); the scheduler does no arithmetic. Wrap-around and overflow are the ALU's behaviour.
- Requests arriving in ISSUE/WAIT/RESP are stalled (ready=0). Requesters must hold valid and payload until ready.
- A requester dropping valid before the handshake is legal; arbitration re-evaluates each cycle.
- rst asserted mid-operation: immediate return to the reset values; the in-flight result is discarded and no response is produced.

Optional Feature:
- Macro ALU_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_ops0 and perf_ops1 (32-bit each): completed-response counts per requester, incremented on the rsp handshake edge.
  - Adds output perf_stall (32-bit): cycles with rsp_valid & !rsp_ready.
  - All three wrap modulo 2^32 and reset to 0.
- Undefined: these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Package alu_sched_pkg holds:
  - opcode constants: OP_CLR=000, OP_THR=001, OP_ADD=010, OP_SUB=011, OP_OR=100, OP_AND=101, OP_XOR=110, OP_HOLD=111;
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the DW default.
- One sub-module, rr_arb2: 2-way round-robin grant from two valids plus last_grant. Purely combinational, instantiated once.

Test Plan:
- Reset check: hold rst=0 for 3 cycles, then release -> all outputs at their reset values, alu_opcode=3'b111, busy=0.
- Single op: req0 ADD a=5 b=3, rsp_ready=1, ALU model with ALU_LAT=1 -> alu_start is a 1-cycle pulse with opcode 010; rsp_valid rises 2 edges after acceptance with rsp_data=8, rsp_id=0.
- Contention: req0 and req1 both valid continuously, req0 ADD 1+1, req1 SUB 0-1 -> responses alternate id 0, 1, 0, 1 with data 2, 32'hFFFFFFFF, 2, 32'hFFFFFFFF.
- Backpressure: XOR a=32'hFFFF0000 b=32'h00FFFF00, rsp_ready=0 for 5 cycles -> rsp_data=32'hFF00FF00 stays stable, req ready stays 0, and the response completes on the first rsp_ready=1 edge.
- Reset mid-op: assert rst in WAIT after an AND request -> next cycle state=IDLE and rsp_valid=0; after release, a new OR 4|1 returns 5.
- ALU_LAT=3 build: ADD 10+20 -> rsp_valid rises 4 edges after acceptance with data 30; with ALU_SCHED_PERF_EN defined, perf_ops0 increments by 1.
